// File: rtl/pulser_burst_if.sv
// pulser_burst_if: sequencer-side inputs and HV pulser IC pins of pulser_burst
// master: drives trigger, runtime config, feedback, abort and error clear
// slave : drives the pulser IC pins, busy/done strobes, error flag and pulse index
interface pulser_burst_if #(
  parameter int CNT_W   = 12,
  parameter int BURST_W = 8
);
  logic               trigger;
  logic [CNT_W-1:0]   high_cycles;
  logic [CNT_W-1:0]   low_cycles;
  logic [BURST_W-1:0] burst_len;
  logic               out_pulse_measure;
  logic               abort;
  logic               reset_all_errors;
  logic               pulser_enable_out;
  logic               pulser_set_out;
  logic               pulse_control_out;
  logic               busy;
  logic               burst_done;
  logic               pulser_ic_error;
  logic [BURST_W-1:0] pulse_index;
  modport master (
    output trigger, high_cycles, low_cycles, burst_len, out_pulse_measure, abort, reset_all_errors,
    input  pulser_enable_out, pulser_set_out, pulse_control_out, busy, burst_done, pulser_ic_error, pulse_index
  );
  modport slave (
    input  trigger, high_cycles, low_cycles, burst_len, out_pulse_measure, abort, reset_all_errors,
    output pulser_enable_out, pulser_set_out, pulse_control_out, busy, burst_done, pulser_ic_error, pulse_index
  );
endinterface

// File: rtl/pulser_burst.sv
// pulser_burst: trigger-edge fired burst of N HV pulses with per-pulse output-stage feedback check
// clk, reset_n (async, active-low) plain ports; all other signals through pulser_burst_if.slave:
//   in : trigger, high_cycles, low_cycles, burst_len, out_pulse_measure, abort, reset_all_errors
//   out: pulser_enable_out, pulser_set_out, pulse_control_out, busy, burst_done, pulser_ic_error, pulse_index
module pulser_burst #(
  parameter int CNT_W       = 12,
  parameter int BURST_W     = 8,
  parameter int VALIDATE_EN = 1,
  parameter int VALIDATE_AT = 2
) (
  input logic          clk,
  input logic          reset_n,
  pulser_burst_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2;
  localparam logic [CNT_W-1:0] VAT = CNT_W'(VALIDATE_AT);
  logic [1:0]         state;
  logic               trig_d, trig_dd, trig_edge;
  logic               en_r, set_r, pco, busy_r, done_r, err;
  logic [CNT_W-1:0]   cnt, h_l, l_l, chk;
  logic [BURST_W-1:0] n_l, idx;
  logic               accept, fail, kill, last_pulse;
  // feedback is sampled at VALIDATE_AT, or on the final high cycle for shorter pulses
  assign chk        = h_l < VAT ? h_l : VAT;
  assign accept     = trig_edge && state == IDLE && !err;
  // abort outranks a feedback failure, so an aborted pulse never raises the error
  assign fail       = VALIDATE_EN != 0 && state == HIGH && cnt == chk && !bus.out_pulse_measure && !bus.abort;
  assign kill       = (bus.abort && state != IDLE) || fail;
  assign last_pulse = idx == n_l - 1'b1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      trig_d    <= 1'b0;
      trig_dd   <= 1'b0;
      trig_edge <= 1'b0;
      en_r      <= 1'b0;
      set_r     <= 1'b0;
      pco       <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
      h_l       <= '0;
      l_l       <= '0;
      n_l       <= '0;
      idx       <= '0;
    end else begin
      trig_d    <= bus.trigger;
      trig_dd   <= trig_d;
      trig_edge <= trig_d & ~trig_dd;
      en_r      <= 1'b1;
      set_r     <= 1'b1;
      done_r    <= 1'b0;
      err       <= fail ? 1'b1 : bus.reset_all_errors ? 1'b0 : err;
      if (kill) begin
        state  <= IDLE;
        pco    <= 1'b0;
        busy_r <= 1'b0;
      end else if (state == IDLE) begin
        if (accept) begin
          state  <= HIGH;
          pco    <= 1'b1;
          busy_r <= 1'b1;
          idx    <= '0;
          cnt    <= CNT_W'(1);
          h_l    <= bus.high_cycles == '0 ? CNT_W'(1) : bus.high_cycles;
          l_l    <= bus.low_cycles == '0 ? CNT_W'(1) : bus.low_cycles;
          n_l    <= bus.burst_len == '0 ? BURST_W'(1) : bus.burst_len;
        end
      end else if (state == HIGH) begin
        if (cnt == h_l) begin
          state <= LOW;
          pco   <= 1'b0;
          cnt   <= CNT_W'(1);
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (cnt == l_l) begin
        if (last_pulse) begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end else begin
          state <= HIGH;
          pco   <= 1'b1;
          idx   <= idx + 1'b1;
          cnt   <= CNT_W'(1);
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
  assign bus.pulser_enable_out = en_r & ~err;
  assign bus.pulser_set_out    = set_r;
  assign bus.pulse_control_out = pco;
  assign bus.busy              = busy_r;
  assign bus.burst_done        = done_r;
  assign bus.pulser_ic_error   = err;
  assign bus.pulse_index       = idx;
endmodule

// File: tb/tb_pulser_burst.sv
// tb_pulser_burst: scoreboard bench; stimulus queues expected burst summaries, a monitor measures and compares them
module tb_pulser_burst;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int passes = 0;
  typedef struct {
    int pulses, hw_min, hw_max, lw_min, lw_max, busy_cyc, idx;
    bit done, err;
  } rec_t;
  rec_t sb[$];
  pulser_burst_if #(.CNT_W(12), .BURST_W(8)) bus ();
  pulser_burst #(.CNT_W(12), .BURST_W(8), .VALIDATE_EN(1), .VALIDATE_AT(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask
  function automatic void expect_burst(input int p, hmin, hmax, lmin, lmax, b, i, input bit d, e);
    rec_t r;
    r.pulses = p; r.hw_min = hmin; r.hw_max = hmax; r.lw_min = lmin; r.lw_max = lmax;
    r.busy_cyc = b; r.idx = i; r.done = d; r.err = e;
    sb.push_back(r);
  endfunction
  task automatic config_burst(input int h, l, n);
    bus.high_cycles = 12'(h);
    bus.low_cycles  = 12'(l);
    bus.burst_len   = 8'(n);
  endtask
  task automatic fire(input string name);
    @(negedge clk) bus.trigger = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 chk({name, "_lat_pre"}, int'(bus.pulse_control_out), 0);
    @(posedge clk);
    #1 chk({name, "_lat_rise"}, int'(bus.pulse_control_out), 1);
    chk({name, "_busy_rise"}, int'(bus.busy), 1);
  endtask
  task automatic wait_idle(input string name, input int lim);
    for (int n = 0; n < lim && bus.busy; n++) begin
      @(posedge clk);
      #1;
    end
    chk({name, "_idle_timeout"}, int'(bus.busy), 0);
    @(negedge clk) bus.trigger = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask
  // monitor: summarises each burst from busy rise to busy fall and checks it against the queue
  int m_pulses, m_hmin, m_hmax, m_lmin, m_lmax, m_busy, m_idx, m_ch, m_cl;
  bit m_pb, m_pp, m_lseen;
  initial begin
    rec_t r;
    m_pb = 1'b0;
    m_pp = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_pb = 1'b0;
        m_pp = 1'b0;
      end else begin
        if (bus.busy && !m_pb) begin
          m_pulses = 0; m_hmin = 0; m_hmax = 0; m_lmin = 0; m_lmax = 0;
          m_busy = 0; m_idx = -1; m_ch = 0; m_cl = 0; m_lseen = 1'b0;
        end
        if (bus.busy) m_busy++;
        if (bus.pulse_control_out && !m_pp) begin
          if (m_cl > 0) begin
            m_lmin = m_lseen && m_lmin < m_cl ? m_lmin : m_cl;
            m_lmax = m_lmax > m_cl ? m_lmax : m_cl;
            m_lseen = 1'b1;
          end
          m_cl = 0;
          m_pulses++;
          m_ch = 0;
          m_idx = int'(bus.pulse_index);
        end
        if (bus.pulse_control_out) m_ch++;
        if (!bus.pulse_control_out && m_pp) begin
          m_hmin = m_pulses > 1 && m_hmin < m_ch ? m_hmin : m_ch;
          m_hmax = m_hmax > m_ch ? m_hmax : m_ch;
        end
        if (bus.busy && !bus.pulse_control_out) m_cl++;
        if (!bus.busy && m_pb) begin
          if (m_cl > 0) begin
            m_lmin = m_lseen && m_lmin < m_cl ? m_lmin : m_cl;
            m_lmax = m_lmax > m_cl ? m_lmax : m_cl;
          end
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_burst actual=%0d pulses required=no burst", m_pulses);
          end else begin
            r = sb.pop_front();
            chk("sb_pulses", m_pulses, r.pulses);
            chk("sb_high_min", m_hmin, r.hw_min);
            chk("sb_high_max", m_hmax, r.hw_max);
            chk("sb_low_min", m_lmin, r.lw_min);
            chk("sb_low_max", m_lmax, r.lw_max);
            chk("sb_busy_cycles", m_busy, r.busy_cyc);
            chk("sb_last_index", m_idx, r.idx);
            chk("sb_burst_done", int'(bus.burst_done), int'(r.done));
            chk("sb_error", int'(bus.pulser_ic_error), int'(r.err));
          end
        end
        m_pb = bus.busy;
        m_pp = bus.pulse_control_out;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.trigger = 1'b0;
    bus.out_pulse_measure = 1'b1;
    bus.abort = 1'b0;
    bus.reset_all_errors = 1'b0;
    config_burst(0, 0, 0);
    #23;
    chk("rst_pco", int'(bus.pulse_control_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_set", int'(bus.pulser_set_out), 0);
    chk("rst_enable", int'(bus.pulser_enable_out), 0);
    chk("rst_error", int'(bus.pulser_ic_error), 0);
    chk("rst_index", int'(bus.pulse_index), 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1 chk("post_rst_set", int'(bus.pulser_set_out), 1);
    chk("post_rst_enable", int'(bus.pulser_enable_out), 1);
    repeat (3) @(posedge clk);
    // single long pulse
    config_burst(3, 2400, 1);
    expect_burst(1, 3, 3, 2400, 2400, 2403, 0, 1'b1, 1'b0);
    fire("single");
    wait_idle("single", 3000);
    // four-pulse burst with a re-trigger mid-burst
    config_burst(5, 10, 4);
    expect_burst(4, 5, 5, 10, 10, 60, 3, 1'b1, 1'b0);
    fire("burst");
    @(negedge clk) bus.trigger = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk) bus.trigger = 1'b1;
    config_burst(50, 50, 9);
    wait_idle("burst", 200);
    // feedback failure on the second pulse
    config_burst(8, 4, 3);
    expect_burst(2, 2, 8, 4, 4, 14, 1, 1'b0, 1'b1);
    fire("fbfail");
    for (int n = 0; n < 100 && !(bus.pulse_index == 8'd1 && bus.pulse_control_out); n++) @(negedge clk);
    bus.out_pulse_measure = 1'b0;
    wait_idle("fbfail", 100);
    bus.out_pulse_measure = 1'b1;
    chk("fbfail_error", int'(bus.pulser_ic_error), 1);
    chk("fbfail_enable", int'(bus.pulser_enable_out), 0);
    @(negedge clk) bus.trigger = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("err_blocks_busy", int'(bus.busy), 0);
    chk("err_blocks_pco", int'(bus.pulse_control_out), 0);
    @(negedge clk) bus.trigger = 1'b0;
    bus.reset_all_errors = 1'b1;
    @(posedge clk);
    #1 bus.reset_all_errors = 1'b0;
    chk("clear_error", int'(bus.pulser_ic_error), 0);
    chk("clear_enable", int'(bus.pulser_enable_out), 1);
    repeat (2) @(posedge clk);
    config_burst(3, 2, 2);
    expect_burst(2, 3, 3, 2, 2, 10, 1, 1'b1, 1'b0);
    fire("after_clear");
    wait_idle("after_clear", 100);
    // abort at high cycle 50 of the first pulse
    config_burst(100, 5, 2);
    expect_burst(1, 50, 50, 0, 0, 50, 0, 1'b0, 1'b0);
    fire("abort");
    repeat (49) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    chk("abort_pco", int'(bus.pulse_control_out), 0);
    chk("abort_busy", int'(bus.busy), 0);
    wait_idle("abort", 10);
    chk("abort_no_error", int'(bus.pulser_ic_error), 0);
    // zero config behaves as 1/1/1
    config_burst(0, 0, 0);
    expect_burst(1, 1, 1, 1, 1, 2, 0, 1'b1, 1'b0);
    fire("zero");
    wait_idle("zero", 20);
    // failure and clear in the same cycle: the set wins
    bus.out_pulse_measure = 1'b0;
    bus.reset_all_errors = 1'b1;
    expect_burst(1, 1, 1, 0, 0, 1, 0, 1'b0, 1'b1);
    fire("set_wins");
    @(posedge clk);
    #1 bus.reset_all_errors = 1'b0;
    chk("set_wins_error", int'(bus.pulser_ic_error), 1);
    bus.out_pulse_measure = 1'b1;
    wait_idle("set_wins", 20);
    @(negedge clk) bus.reset_all_errors = 1'b1;
    @(posedge clk);
    #1 bus.reset_all_errors = 1'b0;
    chk("set_wins_cleared", int'(bus.pulser_ic_error), 0);
    // asynchronous reset in the middle of a high phase
    config_burst(10, 5, 1);
    fire("areset");
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    bus.trigger = 1'b0;
    #1 chk("areset_pco", int'(bus.pulse_control_out), 0);
    chk("areset_busy", int'(bus.busy), 0);
    chk("areset_set", int'(bus.pulser_set_out), 0);
    chk("areset_enable", int'(bus.pulser_enable_out), 0);
    chk("areset_index", int'(bus.pulse_index), 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1 chk("areset_set_back", int'(bus.pulser_set_out), 1);
    chk("areset_enable_back", int'(bus.pulser_enable_out), 1);
    chk("areset_idle", int'(bus.busy), 0);
    repeat (10) @(posedge clk);
    #1 chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
